// File: rtl/const_fetch_ctrl.sv
// Strided constant-vector fetch sequencer: issues up to four constant-memory reads per
// cycle, assembles the returned words into a LANES-wide vector and hands it off via valid/ready.
module const_fetch_ctrl #(
  parameter int LANES     = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W     = $clog2(LANES) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_base,
  input  logic [7:0]                req_stride,
  input  logic [CNT_W-1:0]          req_count,
  output logic [31:0]               mem_addr1,
  output logic [31:0]               mem_addr2,
  output logic [31:0]               mem_addr3,
  output logic [31:0]               mem_addr4,
  input  logic [31:0]               mem_data1,
  input  logic [31:0]               mem_data2,
  input  logic [31:0]               mem_data3,
  input  logic [31:0]               mem_data4,
  output logic [LANES*DATA_W-1:0]   vec_out,
  output logic                      vec_valid,
  input  logic                      vec_ready,
  output logic                      busy,
  output logic                      err_oob
);

  localparam int BEATS_MAX = LANES / 4;
  localparam int BEAT_W    = $clog2(BEATS_MAX) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            state;
  logic [31:0]       base_q;
  logic [7:0]        stride_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] last_q;
  logic [31:0]       addr_q [4];
  logic [3:0]        act_q;

  logic [31:0]       rdata [4];
  logic [3:0]        oob;
  logic [CNT_W-1:0]  req_cnt_sat;
  logic [BEAT_W-1:0] req_last;

  logic [31:0]       src_base;
  logic [7:0]        src_stride;
  logic [CNT_W-1:0]  src_cnt;
  logic [BEAT_W-1:0] nb;
  logic [31:0]       nxt_addr [4];
  logic [3:0]        nxt_act;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    if (32'(c) > 32'(LANES)) return CNT_W'(LANES);
    return c;
  endfunction

  // Full 32-bit product, truncated; wraps modulo 2^32.
  function automatic logic [31:0] lane_addr(input logic [31:0] base, input logic [7:0] stride,
                                            input logic [31:0] lane);
    return base + (lane * {24'd0, stride});
  endfunction

  function automatic logic addr_oob(input logic [31:0] a);
    return a >= 32'(MEM_DEPTH);
  endfunction

  assign rdata[0] = mem_data1;
  assign rdata[1] = mem_data2;
  assign rdata[2] = mem_data3;
  assign rdata[3] = mem_data4;

  assign mem_addr1 = addr_q[0];
  assign mem_addr2 = addr_q[1];
  assign mem_addr3 = addr_q[2];
  assign mem_addr4 = addr_q[3];

  assign req_cnt_sat = sat_count(req_count);
  // Zero-count requests get a single empty beat so vec_valid rises one edge after accept.
  assign req_last    = (req_cnt_sat == '0) ? '0 : BEAT_W'((32'(req_cnt_sat) - 32'd1) >> 2);

  always_comb begin
    for (int unsigned p = 0; p < 4; p++) oob[p] = addr_oob(addr_q[p]);
  end

  // Addresses for the beat that follows the next edge: beat 0 on accept, else beat_q+1.
  always_comb begin
    src_base   = base_q;
    src_stride = stride_q;
    src_cnt    = cnt_q;
    nb         = beat_q + BEAT_W'(1);
    if (state == IDLE) begin
      src_base   = req_base;
      src_stride = req_stride;
      src_cnt    = req_cnt_sat;
      nb         = '0;
    end
    for (int unsigned p = 0; p < 4; p++) begin
      nxt_act[p]  = (32'(nb) * 32'd4 + p) < 32'(src_cnt);
      nxt_addr[p] = nxt_act[p] ? lane_addr(src_base, src_stride, 32'(nb) * 32'd4 + p) : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      last_q    <= '0;
      act_q     <= '0;
      for (int p = 0; p < 4; p++) addr_q[p] <= '0;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      err_oob   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= FETCH;
            base_q    <= req_base;
            stride_q  <= req_stride;
            cnt_q     <= req_cnt_sat;
            beat_q    <= '0;
            last_q    <= req_last;
            act_q     <= nxt_act;
            for (int p = 0; p < 4; p++) addr_q[p] <= nxt_addr[p];
            vec_out   <= '0;
            err_oob   <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          for (int p = 0; p < 4; p++) begin
            if (act_q[p])
              vec_out[(int'(beat_q) * 4 + p) * DATA_W +: DATA_W] <=
                oob[p] ? '0 : DATA_W'(rdata[p]);
          end
          if (|(act_q & oob)) err_oob <= 1'b1;
          if (beat_q == last_q) begin
            state     <= DONE;
            vec_valid <= 1'b1;
            act_q     <= '0;
            for (int p = 0; p < 4; p++) addr_q[p] <= '0;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
            act_q  <= nxt_act;
            for (int p = 0; p < 4; p++) addr_q[p] <= nxt_addr[p];
          end
        end
        DONE: begin
          if (vec_ready) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          vec_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
